point_stream_decoder: RTL and testbench
=======================================

Name: point_stream_decoder

Overview:
- Sits between `uart_rx` and the line-draw `control` block.
- Assembles received UART bytes into 32-bit point words and recognises frame start and the done command.
- Buffers decoded points in a FIFO and issues single-cycle draw/jump commands to `control` under its ready handshake.
- Decouples the bursty serial input from line-drawing time.

Parameters:
- FIFO_DEPTH, 16, point FIFO entries; power of two, at least 2.
- TIMEOUT, 50000, idle clk cycles mid-word before the partial word is discarded.
- CW, 12, coordinate width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle byte strobe from `uart_rx` (`o_Rx_DV`)
- rx_byte  in  8  received byte, valid with rx_valid
- ready  in  1  `control` is idle and can accept a command
- x  out  CW  target X; held between commands
- y  out  CW  target Y; held between commands
- draw  out  1  one-cycle pulse: draw line to (x,y)
- jump  out  1  one-cycle pulse: blanked move to (x,y)
- in_frame  out  1  high between frame start and done command
- frame_done  out  1  one-cycle pulse when the done command is accepted
- overflow  out  1  sticky; a point was dropped because the FIFO was full
- bad_word  out  1  sticky; a malformed word was discarded
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: x=0, y=0, draw=0, jump=0, in_frame=0, frame_done=0, overflow=0, bad_word=0, fifo_level=0. Byte counter=0, timeout counter=0, state IDLE.
- Word format: big-endian; the first byte is word[31:24].
  - word[31]=1 marks a point.
  - word[30:25] reserved, ignored.
  - word[24]: 1=jump, 0=draw.
  - x=word[23:12], y=word[11:0].
  - DONE_WORD=32'h01010101.
- Assembler states: IDLE, FRAME.
- IDLE:
  - rx_valid with rx_byte==0: discarded.
  - First nonzero byte: go to FRAME, in_frame=1, and the byte is taken as byte 0 of the first word.
- FRAME: each rx_valid shifts the byte in and increments the byte counter (wraps 3→0). On the 4th byte the complete word is classified on the next cycle:
  - DONE_WORD: frame_done pulses, in_frame=0, return to IDLE; nothing is written to the FIFO.
  - word[31]=1: push {jump_flag, x, y} to the FIFO.
  - Anything else: discarded, bad_word set, stay in FRAME.
- Timeout:
  - Timeout counter resets on every rx_valid and counts only while the byte counter is nonzero.
  - Reaching TIMEOUT: byte counter cleared, partial word discarded, bad_word set, state unchanged.
- Overflow: a push while the FIFO is full drops the point and sets overflow. FIFO contents are unaffected.
- Command issue:
  - A command issues when ready=1, the FIFO is not empty, and no command issued in the previous cycle. The one-cycle gap lets `control` drop ready.
  - On issue: pop the FIFO; x and y update in the same cycle that draw or jump is asserted. Exactly one of draw/jump is high.
- Latency: 4th byte strobe at cycle N → FIFO write at N+1 → earliest draw/jump at N+2 (FIFO empty, ready high).
- Simultaneous push and pop: both occur and level is unchanged. A push while full is dropped even if a pop occurs in the same cycle.
- Done with points still queued: the FIFO keeps draining after in_frame falls.
- Reset mid-operation: all state, including FIFO pointers and sticky flags, returns to reset values next cycle. Any in-flight command pulse is suppressed.
- Points are issued in received order; there is no reordering.

Decomposition:
- Package `vector_pkg`:
  - DONE_WORD, POINT_MARK_BIT=31, JUMP_BIT=24, X_MSB/X_LSB, Y_MSB/Y_LSB, CW.
  - Packed point type {jump, x[CW-1:0], y[CW-1:0]}, 25 bits.
- Sub-module `point_fifo`: synchronous single-clock FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - First-word fall-through, so dout is valid whenever empty=0.

Test Plan:
- Bytes 00,00,81,64,0C,80 with ready=1 → in_frame rises on 0x81; word 0x81640C80 gives jump=1, x=0x640, y=0xC80; jump pulses exactly at N+2 after the last byte.
- Points 0x80001002, 0x80003004, then 01,01,01,01 with ready=1 → draw (1,2), draw (3,4), frame_done one pulse, in_frame=0, FIFO empty.
- ready=0; send 18 points with FIFO_DEPTH=16 → fifo_level=16, overflow=1. Then ready=1 → exactly 16 draws in order (first 16 points), overflow remains 1.
- Send 0x12345678 mid-frame → no command issued, bad_word=1, next valid point decodes correctly.
- Send 2 bytes, idle TIMEOUT cycles, then 4-byte point 0x80005006 → bad_word=1, draw x=5, y=6.
- With ready held 1 and 3 points queued → draw pulses never in consecutive cycles; reset asserted mid-drain → all outputs return to 0 the next cycle and no further pulses occur.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared word-format constants, point type and assembler states for the point stream decoder.
package vector_pkg;

  localparam int CW             = 12;
  localparam logic [31:0] DONE_WORD = 32'h01010101;
  localparam int POINT_MARK_BIT = 31;
  localparam int JUMP_BIT       = 24;
  localparam int X_MSB          = 23;
  localparam int X_LSB          = 12;
  localparam int Y_MSB          = 11;
  localparam int Y_LSB          = 0;

  typedef struct packed {
    logic          jump;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } asm_state_t;

  function automatic point_t word_to_point(input logic [31:0] w);
    point_t p;
    p.jump = w[JUMP_BIT];
    p.x    = w[X_MSB:X_LSB];
    p.y    = w[Y_MSB:Y_LSB];
    return p;
  endfunction

endpackage

// File: rtl/point_fifo.sv
// Single-clock first-word-fall-through FIFO; dout valid whenever empty=0, zero read latency.
// Pushes while full are ignored and pops while empty are ignored; the caller flags drops.
module point_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push while full is dropped even when a pop frees a slot in the same cycle.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/point_stream_decoder.sv
// Assembles UART bytes into point words, queues points and issues draw/jump pulses to control.
// 4th byte at N -> FIFO write N+1 -> earliest command N+2; commands wait for ready with a 1-cycle gap.
import vector_pkg::*;

module point_stream_decoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 50000,
  parameter int CW         = vector_pkg::CW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  input  logic                          ready,
  output logic [CW-1:0]                 x,
  output logic [CW-1:0]                 y,
  output logic                          draw,
  output logic                          jump,
  output logic                          in_frame,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          bad_word,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = $clog2(TIMEOUT + 1);

  asm_state_t     state_q;
  logic [1:0]     cnt_q;
  logic [31:0]    word_q;
  logic           word_vld_q;
  logic [TW-1:0]  tmo_q;
  logic [CW-1:0]  x_q;
  logic [CW-1:0]  y_q;
  logic           draw_q;
  logic           jump_q;
  logic           in_frame_q;
  logic           frame_done_q;
  logic           overflow_q;
  logic           bad_word_q;

  point_t         fifo_din;
  point_t         fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           is_done;

  assign is_done  = (word_q == DONE_WORD);
  assign fifo_din = word_to_point(word_q);
  assign push     = word_vld_q && !is_done && word_q[POINT_MARK_BIT];
  // A command registered last cycle blocks issue so control has time to drop ready.
  assign pop      = ready && !fifo_empty && !(draw_q || jump_q);

  point_fifo #(
    .WIDTH ($bits(point_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      word_vld_q   <= 1'b0;
      tmo_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      draw_q       <= 1'b0;
      jump_q       <= 1'b0;
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      bad_word_q   <= 1'b0;
    end else begin
      draw_q       <= 1'b0;
      jump_q       <= 1'b0;
      frame_done_q <= 1'b0;
      word_vld_q   <= 1'b0;

      if (pop) begin
        x_q    <= fifo_dout.x;
        y_q    <= fifo_dout.y;
        jump_q <= fifo_dout.jump;
        draw_q <= !fifo_dout.jump;
      end

      if (push && fifo_full) overflow_q <= 1'b1;

      if (word_vld_q) begin
        if (is_done) begin
          frame_done_q <= 1'b1;
          in_frame_q   <= 1'b0;
          state_q      <= ST_IDLE;
        end else if (!word_q[POINT_MARK_BIT]) begin
          bad_word_q <= 1'b1;
        end
      end

      if (rx_valid) begin
        tmo_q <= '0;
        case (state_q)
          ST_IDLE: begin
            // Leading zero bytes are line noise before the frame proper.
            if (rx_byte != 8'h00) begin
              state_q    <= ST_FRAME;
              in_frame_q <= 1'b1;
              word_q     <= {word_q[23:0], rx_byte};
              cnt_q      <= 2'd1;
            end
          end
          default: begin
            word_q <= {word_q[23:0], rx_byte};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) word_vld_q <= 1'b1;
          end
        endcase
      end else if (cnt_q != 2'd0) begin
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          cnt_q      <= '0;
          tmo_q      <= '0;
          bad_word_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign draw       = draw_q;
  assign jump       = jump_q;
  assign in_frame   = in_frame_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign bad_word   = bad_word_q;

endmodule

// File: tb/tb_point_stream_decoder.sv
// Directed-vector bench for point_stream_decoder with a pulse monitor feeding a command log.
module tb_point_stream_decoder;

  localparam int DEPTH = 16;
  localparam int TMO   = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        ready;
  logic [11:0] x;
  logic [11:0] y;
  logic        draw;
  logic        jump;
  logic        in_frame;
  logic        frame_done;
  logic        overflow;
  logic        bad_word;
  logic [4:0]  fifo_level;

  int n_vec  = 0;
  int n_miss = 0;

  logic [24:0] cmd_log[$];
  int          done_cnt   = 0;
  int          consec_cnt = 0;
  logic        prev_pulse = 1'b0;

  always #5 clk = ~clk;

  point_stream_decoder #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO),
    .CW         (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .ready      (ready),
    .x          (x),
    .y          (y),
    .draw       (draw),
    .jump       (jump),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .overflow   (overflow),
    .bad_word   (bad_word),
    .fifo_level (fifo_level)
  );

  always @(negedge clk) begin
    if (draw || jump) cmd_log.push_back({jump, x, y});
    if ((draw || jump) && prev_pulse) consec_cnt++;
    if (draw && jump) consec_cnt++;
    prev_pulse = draw || jump;
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    idle(2);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) send_byte(t[i*8 +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [24:0] e;
    int          waited;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    ready    = 1'b0;
    idle(3);
    reset = 1'b0;
    #1;

    chk("rst_x",     {20'd0, x}, 32'h0);
    chk("rst_y",     {20'd0, y}, 32'h0);
    chk("rst_pulse", {29'd0, draw, jump, frame_done}, 32'h0);
    chk("rst_flags", {29'd0, in_frame, overflow, bad_word}, 32'h0);
    chk("rst_level", {27'd0, fifo_level}, 32'h0);

    // Leading zeros, then jump point 0x81640C80 with exact issue timing.
    ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zero_bytes_idle", {31'd0, in_frame}, 32'h0);
    send_byte(8'h81);
    chk("in_frame_rise", {31'd0, in_frame}, 32'h1);
    send_byte(8'h64);
    send_byte(8'h0C);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h80;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("jump_n1", {30'd0, draw, jump}, 32'h0);
    @(negedge clk);
    chk("jump_n2", {30'd0, draw, jump}, 32'h1);
    chk("jump_xy", {8'd0, x, y}, 32'h00640C80);
    @(negedge clk);
    chk("jump_1cyc", {30'd0, draw, jump}, 32'h0);
    idle(3);
    cmd_log.delete();

    // Two draw points followed by the done word.
    send_word(32'h80001002);
    send_word(32'h80003004);
    send_word(32'h01010101);
    idle(10);
    #1;
    chk("pts_count", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      chk("pt0", {7'd0, cmd_log[0]}, {7'd0, 1'b0, 12'd1, 12'd2});
      chk("pt1", {7'd0, cmd_log[1]}, {7'd0, 1'b0, 12'd3, 12'd4});
    end
    chk("done_pulses",   done_cnt, 1);
    chk("done_in_frame", {31'd0, in_frame}, 32'h0);
    chk("done_level",    {27'd0, fifo_level}, 32'h0);
    cmd_log.delete();

    // Overflow: 18 points with control busy, then drain.
    ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      w = 32'h80000000 | (32'(i + 1) << 12) | 32'(i + 256);
      send_word(w);
    end
    #1;
    chk("ovf_level", {27'd0, fifo_level}, 32'd16);
    chk("ovf_flag",  {31'd0, overflow}, 32'h1);
    chk("ovf_no_cmd", cmd_log.size(), 0);
    ready = 1'b1;
    idle(60);
    #1;
    chk("drain_count", cmd_log.size(), 16);
    if (cmd_log.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        e = {1'b0, 12'(i + 1), 12'(i + 256)};
        chk($sformatf("drain_%0d", i), {7'd0, cmd_log[i]}, {7'd0, e});
      end
    end
    chk("ovf_sticky",  {31'd0, overflow}, 32'h1);
    chk("drain_level", {27'd0, fifo_level}, 32'h0);
    cmd_log.delete();

    // Malformed word mid-frame, then a good point.
    chk("bad_pre", {31'd0, bad_word}, 32'h0);
    send_word(32'h12345678);
    idle(2);
    #1;
    chk("bad_set",    {31'd0, bad_word}, 32'h1);
    chk("bad_no_cmd", cmd_log.size(), 0);
    send_word(32'h80007008);
    idle(4);
    #1;
    chk("bad_next_cnt", cmd_log.size(), 1);
    if (cmd_log.size() == 1) chk("bad_next_pt", {7'd0, cmd_log[0]}, {7'd0, 1'b0, 12'd7, 12'd8});
    cmd_log.delete();

    // Timeout discards a 2-byte partial word.
    do_reset();
    #1;
    chk("tmo_bad_clr", {31'd0, bad_word}, 32'h0);
    send_byte(8'h80);
    send_byte(8'h00);
    idle(TMO + 5);
    #1;
    chk("tmo_bad_set", {31'd0, bad_word}, 32'h1);
    send_word(32'h80005006);
    idle(4);
    #1;
    chk("tmo_cnt", cmd_log.size(), 1);
    if (cmd_log.size() == 1) chk("tmo_pt", {7'd0, cmd_log[0]}, {7'd0, 1'b0, 12'd5, 12'd6});
    cmd_log.delete();

    // Three queued points, reset mid-drain.
    ready = 1'b0;
    send_word(32'h80009001);
    send_word(32'h8000A002);
    send_word(32'h8000B003);
    #1;
    chk("q3_level", {27'd0, fifo_level}, 32'd3);
    consec_cnt = 0;
    @(negedge clk);
    ready  = 1'b1;
    waited = 0;
    while (cmd_log.size() < 2 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("drain_start", cmd_log.size(), 2);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_pulse", {29'd0, draw, jump, frame_done}, 32'h0);
    chk("mid_rst_xy",    {8'd0, x, y}, 32'h0);
    chk("mid_rst_flags", {29'd0, in_frame, overflow, bad_word}, 32'h0);
    chk("mid_rst_level", {27'd0, fifo_level}, 32'h0);
    reset = 1'b0;
    idle(20);
    #1;
    chk("post_rst_cmds", cmd_log.size(), 2);
    chk("no_consec",     consec_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
